ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Sequences the configuration flip-flop chain (ccff_head → … → ccff_tail) that threads through the grid IO tiles and logic tiles.
- Accepts bitstream words from a host-side valid/ready source and serialises exactly CHAIN_LEN bits into the chain.
- Generates the shift-enable that gates prog_clk to the chain, and reports busy/done.
- Sits between the host configuration port and the fabric's first ccff_head.

Parameters:
- WORD_W, 32, width of bitstream words from host
- CHAIN_LEN, 16, total configuration bits in the chain (≥1)
- CNT_W, $clog2(CHAIN_LEN+1), width of bit counter (derived, not overridden)

Ports:
- prog_clk  in  1  programming clock; all state on rising edge
- pReset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a programming pass
- abort  in  1  one-cycle pulse; terminate pass
- word_data  in  WORD_W  bitstream word, MSB shifted first
- word_valid  in  1  host word valid
- word_ready  out  1  loader accepts word this cycle
- ccff_head  out  1  serial data into chain
- ccff_tail  in  1  serial data out of chain
- shift_en  out  1  chain clock-gate enable; chain shifts on edges where high
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse, pass complete
- rb_sig  out  16  readback signature (see Optional Feature)

Behaviour:
- Reset (pReset low, async): state IDLE; word_ready=0, ccff_head=0, shift_en=0, busy=0, done=0, bit counter=0, shift register=0, rb_sig=0.
- FSM states: IDLE, FETCH, SHIFT, FINISH.
- IDLE: start=1 → FETCH, bit counter cleared, busy=1 next cycle. start ignored in every other state.
- FETCH: word_ready=1. On word_valid & word_ready, load word into shift register, load word-bit counter = WORD_W → SHIFT. No shift_en in FETCH.
- SHIFT: shift_en=1 and ccff_head = shift register MSB, both registered outputs valid during the same cycle. Each SHIFT cycle shifts register left by one, increments total bit counter, decrements word-bit counter.
  - Total counter reaches CHAIN_LEN on this cycle → FINISH. Any remaining bits of the current word are discarded.
  - Else word-bit counter reaches 0 → FETCH.
- FINISH: shift_en=0, word_ready=0, done=1 for exactly one cycle → IDLE, busy=0.
- Latency: a pass with host always valid takes ceil(CHAIN_LEN/WORD_W) FETCH cycles + CHAIN_LEN SHIFT cycles + 1 FINISH cycle after start.
- shift_en never high outside SHIFT. Exactly CHAIN_LEN shift_en cycles per completed pass.
- word_valid stalls: loader stays in FETCH indefinitely; shift_en stays low, chain holds.
- abort (any non-IDLE state) → IDLE next cycle, shift_en=0, busy=0, no done pulse. Chain contents undefined. abort in IDLE has no effect. Simultaneous abort and word handshake: abort wins, word is consumed and dropped.
- Async reset mid-pass: same as abort, immediate.
- CHAIN_LEN < WORD_W: a single word is fetched and its top CHAIN_LEN bits are shifted.

Optional Feature:
- Macro CCFF_READBACK_EN.
- Defined: during every SHIFT cycle, rb_sig updates as a CRC-16-CCITT (poly 0x1021, MSB-first) of the sampled ccff_tail. rb_sig is cleared to 0xFFFF on start and held after FINISH until the next start. This lets the host verify the previous bitstream while the new one loads.
- Not defined: rb_sig is tied to 0 and ccff_tail is unused.

Decomposition:
- Package ccff_loader_pkg holds:
  - FSM state enum (IDLE/FETCH/SHIFT/FINISH, 2-bit)
  - CRC16_POLY = 16'h1021
  - CRC16_INIT = 16'hFFFF
- One natural sub-module: ccff_crc16_serial, a 1-bit-per-cycle CRC with clear/enable, instantiated only under CCFF_READBACK_EN.

Test Plan:
- CHAIN_LEN=16, WORD_W=32, start, word 0xA5C3_0000 always valid → 16 shift_en cycles, ccff_head sequence 1010_0101_1100_0011, done pulse 18 cycles after start, low 16 bits discarded.
- CHAIN_LEN=70, WORD_W=32, host inserts 5-cycle valid gaps → 3 words fetched, shift_en low throughout each gap, total shift_en count = 70, one done pulse.
- abort asserted after 7 SHIFT cycles → busy=0 next cycle, shift_en=0, no done; following start completes a full 16-bit pass normally.
- pReset asserted low mid-SHIFT (asynchronous to the clock edge) → all outputs zero immediately; start pulse while busy is ignored with no counter restart.
- CCFF_READBACK_EN, ccff_tail driven with 0xFFFF over 16 shifts → rb_sig equals the CRC-16-CCITT of 16 ones from init 0xFFFF. Without the macro, rb_sig=0.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } ccff_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first CRC-16-CCITT step for a single input bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ din) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear to the init value.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Clear wins over update; otherwise fold one bit per enabled cycle.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream words into the configuration flip-flop chain.
// Optional readback signature of the outgoing chain contents: CCFF_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | word_ready high, waiting for a host word
// SHIFT  | shift_en high, one bit into ccff_head per cycle
// FINISH | one-cycle done pulse
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       rb_sig
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WORD_BITS = WCNT_W'(WORD_W);

    ccff_state_e         state_q, state_d;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    // Next-state, shift register and counters. Abort beats a same-cycle word handshake.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    bit_cnt_d = '0;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (word_valid) begin
                    sr_d    = word_data;
                    wcnt_d  = WORD_BITS;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d      = sr_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                wcnt_d    = wcnt_q - WCNT_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_cnt_q == LAST_BIT) begin
                    // Chain full: leftover bits of the current word are dropped.
                    state_d = FINISH;
                end else if (wcnt_q == WCNT_W'(1)) begin
                    state_d = FETCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, data and counter registers.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Outputs decode straight from registers so they are glitch-free for the clock gate.
    assign word_ready = (state_q == FETCH);
    assign shift_en   = (state_q == SHIFT);
    assign ccff_head  = (state_q == SHIFT) && sr_q[WORD_W-1];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);

`ifdef CCFF_READBACK_EN
    // Signature of the old chain contents as they fall out of ccff_tail.
    ccff_crc16_serial u_crc (
        .clk   (prog_clk),
        .rst_n (pReset),
        .clr   ((state_q == IDLE) && start),
        .en    (state_q == SHIFT),
        .din   (ccff_tail),
        .crc   (rb_sig)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_sig      = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised self-checking bench: a 16-bit and a 70-bit chain loader share the host bus.
module tb_ccff_chain_loader;

    localparam int WORD_W = 32;
    localparam int LEN_A  = 16;
    localparam int LEN_B  = 70;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              start_a, start_b, abort, word_valid;
    logic [WORD_W-1:0] word_data;
    logic              ready_a, head_a, tail_a, sen_a, busy_a, done_a;
    logic              ready_b, head_b, tail_b, sen_b, busy_b, done_b;
    logic [15:0]       rb_a, rb_b;
    logic [LEN_A-1:0]  chain_a = '1;
    logic              sen_s = 1'b0;
    logic              head_s = 1'b0;
    int                checks = 0;
    int                errors = 0;
    logic [WORD_W-1:0] words_q[$];
    int                gaps_q[$];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_A)) u_dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(ready_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .shift_en(sen_a), .busy(busy_a),
        .done(done_a), .rb_sig(rb_a)
    );

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_B)) u_dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(ready_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .shift_en(sen_b), .busy(busy_b),
        .done(done_b), .rb_sig(rb_b)
    );

    // Behavioural model of the 16-bit chain: shifts on clock edges where shift_en was high.
    always @(negedge prog_clk) begin
        sen_s  <= sen_a;
        head_s <= head_a;
    end
    always @(posedge prog_clk) begin
        if (sen_s) chain_a <= {chain_a[LEN_A-2:0], head_s};
    end
    assign tail_a = chain_a[LEN_A-1];
    assign tail_b = 1'b0;

    function automatic logic [15:0] crc_ref(input logic [LEN_A-1:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = LEN_A - 1; i >= 0; i--) begin
            if ((c[15] ^ bits[i]) == 1'b1) c = (c << 1) ^ 16'h1021;
            else c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_rb(input logic [LEN_A-1:0] snap);
`ifdef CCFF_READBACK_EN
        return crc_ref(snap);
`else
        return (snap == snap) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    // First len bits of the queued words, MSB of each word first.
    function automatic logic [127:0] exp_seq(input int len);
        logic [127:0]      r;
        logic [WORD_W-1:0] w;
        r = '0;
        for (int i = 0; i < len; i++) begin
            w = words_q[i / WORD_W];
            r = {r[126:0], w[WORD_W - 1 - (i % WORD_W)]};
        end
        return r;
    endfunction

    function automatic int exp_done(input int len);
        int n, t;
        n = (len + WORD_W - 1) / WORD_W;
        t = len + 1;
        for (int k = 0; k < n; k++) t += gaps_q[k] + 1;
        return t;
    endfunction

    function automatic logic cur_ready(input bit sel); return sel ? ready_b : ready_a; endfunction
    function automatic logic cur_sen(input bit sel);   return sel ? sen_b   : sen_a;   endfunction
    function automatic logic cur_head(input bit sel);  return sel ? head_b  : head_a;  endfunction
    function automatic logic cur_done(input bit sel);  return sel ? done_b  : done_a;  endfunction

    // Drives one pass (called at posedge+1), recording what the loader did cycle by cycle.
    task automatic run_pass(input bit sel, input int gap_lo, input int gap_hi, input int restart_cyc,
                            output int done_cyc, output int n_done, output int sen_cnt,
                            output logic [127:0] seq, output int taken, output int overlap);
        int gap, idx;
        done_cyc = -1; n_done = 0; sen_cnt = 0; seq = '0; taken = 0; overlap = 0;
        gaps_q.delete();
        idx = 0;
        gap = $urandom_range(gap_hi, gap_lo);
        gaps_q.push_back(gap);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        word_valid = 1'b0;
        @(posedge prog_clk); #1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == restart_cyc) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (cur_ready(sel)) begin
                if (gap > 0) begin
                    word_valid = 1'b0;
                    gap--;
                end else begin
                    word_valid = 1'b1;
                    word_data  = (idx < words_q.size()) ? words_q[idx] : '0;
                end
            end else begin
                word_valid = 1'($urandom_range(1, 0));
                word_data  = $urandom;
            end
            @(negedge prog_clk);
            if (cur_ready(sel) && word_valid) begin
                taken++;
                idx++;
                gap = $urandom_range(gap_hi, gap_lo);
                gaps_q.push_back(gap);
            end
            if (cur_sen(sel)) begin
                sen_cnt++;
                seq = {seq[126:0], cur_head(sel)};
                if (cur_ready(sel)) overlap++;
            end
            if (cur_done(sel)) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge prog_clk); #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        word_valid = 1'b0;
    endtask

    task automatic test_reset();
        pReset = 1'b0;
        start_a = 1'b0; start_b = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
        #1;
        checks++;
        if ({ready_a, head_a, sen_a, busy_a, done_a, busy_b, sen_b} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {ready_a, head_a, sen_a, busy_a, done_a, busy_b, sen_b});
        end
        checks++;
        if (rb_a !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rb: got %h required 0000", rb_a);
        end
        @(negedge prog_clk);
        pReset = 1'b1;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_basic();
        int done_cyc, n_done, sen_cnt, taken, overlap;
        logic [127:0] seq;
        logic [LEN_A-1:0] snap;
        words_q.delete();
        words_q.push_back(32'hA5C3_0000);
        snap = chain_a;
        run_pass(1'b0, 0, 0, -1, done_cyc, n_done, sen_cnt, seq, taken, overlap);
        checks++;
        if (seq[15:0] !== 16'hA5C3) begin errors++; $display("FAIL basic_head_seq: got %h required a5c3", seq[15:0]); end
        checks++;
        if (sen_cnt !== 16) begin errors++; $display("FAIL basic_shift_count: got %0d required 16", sen_cnt); end
        checks++;
        if (done_cyc !== 18) begin errors++; $display("FAIL basic_done_latency: got %0d required 18", done_cyc); end
        checks++;
        if (n_done !== 1 || taken !== 1 || overlap !== 0) begin
            errors++;
            $display("FAIL basic_counts: done %0d words %0d overlap %0d required 1 1 0", n_done, taken, overlap);
        end
        @(negedge prog_clk);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy_a); end
        checks++;
        if (rb_a !== exp_rb(snap)) begin errors++; $display("FAIL basic_rb: got %h required %h", rb_a, exp_rb(snap)); end
        @(posedge prog_clk); #1;
    endtask

    task automatic test_gaps();
        int done_cyc, n_done, sen_cnt, taken, overlap;
        logic [127:0] seq, exp;
        words_q.delete();
        for (int i = 0; i < 3; i++) words_q.push_back($urandom);
        run_pass(1'b1, 5, 5, -1, done_cyc, n_done, sen_cnt, seq, taken, overlap);
        exp = exp_seq(LEN_B);
        checks++;
        if (seq[LEN_B-1:0] !== exp[LEN_B-1:0]) begin
            errors++;
            $display("FAIL gaps_head_seq: got %h required %h", seq[LEN_B-1:0], exp[LEN_B-1:0]);
        end
        checks++;
        if (sen_cnt !== LEN_B) begin errors++; $display("FAIL gaps_shift_count: got %0d required %0d", sen_cnt, LEN_B); end
        checks++;
        if (taken !== 3) begin errors++; $display("FAIL gaps_words: got %0d required 3", taken); end
        checks++;
        if (n_done !== 1 || overlap !== 0) begin
            errors++;
            $display("FAIL gaps_done_overlap: done %0d overlap %0d required 1 0", n_done, overlap);
        end
        checks++;
        if (done_cyc !== exp_done(LEN_B)) begin
            errors++;
            $display("FAIL gaps_latency: got %0d required %0d", done_cyc, exp_done(LEN_B));
        end
    endtask

    task automatic test_abort();
        int cnt, bad, done_cyc, n_done, sen_cnt, taken, overlap;
        logic [127:0] seq, exp;
        start_a = 1'b1;
        @(posedge prog_clk); #1;
        start_a = 1'b0;
        word_valid = 1'b1;
        word_data = $urandom;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 7; c++) begin
            @(negedge prog_clk);
            if (sen_a) cnt++;
            @(posedge prog_clk); #1;
        end
        word_valid = 1'b0;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        @(negedge prog_clk);
        checks++;
        if (cnt !== 7) begin errors++; $display("FAIL abort_reach_shift: got %0d shifts required 7", cnt); end
        checks++;
        if ({busy_a, sen_a, done_a} !== 3'b000) begin
            errors++;
            $display("FAIL abort_outputs: busy/sen/done got %b required 000", {busy_a, sen_a, done_a});
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge prog_clk);
            if (done_a || sen_a || busy_a) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles required 0", bad); end
        // Abort in FETCH together with a word handshake: the word is dropped.
        @(posedge prog_clk); #1;
        start_a = 1'b1;
        @(posedge prog_clk); #1;
        start_a = 1'b0;
        word_valid = 1'b1;
        word_data = $urandom;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        word_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge prog_clk);
            if (done_a || sen_a || busy_a) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_handshake: got %0d active cycles required 0", bad); end
        @(posedge prog_clk); #1;
        words_q.delete();
        words_q.push_back($urandom);
        run_pass(1'b0, 0, 0, -1, done_cyc, n_done, sen_cnt, seq, taken, overlap);
        exp = exp_seq(LEN_A);
        checks++;
        if (seq[15:0] !== exp[15:0] || sen_cnt !== 16 || done_cyc !== 18 || n_done !== 1) begin
            errors++;
            $display("FAIL abort_next_pass: seq %h shifts %0d done_at %0d dones %0d required %h 16 18 1",
                     seq[15:0], sen_cnt, done_cyc, n_done, exp[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        int cnt, done_cyc, n_done, sen_cnt, taken, overlap;
        logic [127:0] seq, exp;
        start_a = 1'b1;
        @(posedge prog_clk); #1;
        start_a = 1'b0;
        word_valid = 1'b1;
        word_data = $urandom;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge prog_clk);
            if (sen_a) cnt++;
            if (cnt == 5) break;
            @(posedge prog_clk); #1;
        end
        word_valid = 1'b0;
        #2;
        pReset = 1'b0;
        #1;
        checks++;
        if (cnt !== 5) begin errors++; $display("FAIL rstmid_reach_shift: got %0d shifts required 5", cnt); end
        checks++;
        if ({ready_a, head_a, sen_a, busy_a, done_a} !== 5'b0 || rb_a !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b rb %h required 00000 rb 0000",
                     {ready_a, head_a, sen_a, busy_a, done_a}, rb_a);
        end
        @(negedge prog_clk);
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        words_q.delete();
        words_q.push_back($urandom);
        run_pass(1'b0, 0, 2, 6, done_cyc, n_done, sen_cnt, seq, taken, overlap);
        exp = exp_seq(LEN_A);
        checks++;
        if (seq[15:0] !== exp[15:0] || sen_cnt !== 16) begin
            errors++;
            $display("FAIL restart_ignored_seq: seq %h shifts %0d required %h 16", seq[15:0], sen_cnt, exp[15:0]);
        end
        checks++;
        if (done_cyc !== exp_done(LEN_A) || n_done !== 1) begin
            errors++;
            $display("FAIL restart_ignored_done: at %0d count %0d required %0d 1", done_cyc, n_done, exp_done(LEN_A));
        end
    endtask

    task automatic test_readback();
        int done_cyc, n_done, sen_cnt, taken, overlap;
        logic [127:0] seq, exp;
        logic [LEN_A-1:0] snap;
        logic [15:0] clr_val;
`ifdef CCFF_READBACK_EN
        clr_val = 16'hFFFF;
`else
        clr_val = 16'h0000;
`endif
        start_a = 1'b1;
        @(posedge prog_clk); #1;
        start_a = 1'b0;
        @(negedge prog_clk);
        checks++;
        if (rb_a !== clr_val) begin errors++; $display("FAIL rb_clear_on_start: got %h required %h", rb_a, clr_val); end
        @(posedge prog_clk); #1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        for (int p = 0; p < 5; p++) begin
            words_q.delete();
            words_q.push_back($urandom);
            snap = chain_a;
            run_pass(1'b0, 0, 3, -1, done_cyc, n_done, sen_cnt, seq, taken, overlap);
            exp = exp_seq(LEN_A);
            checks++;
            if (seq[15:0] !== exp[15:0] || sen_cnt !== 16 || n_done !== 1 || overlap !== 0) begin
                errors++;
                $display("FAIL rand_pass%0d: seq %h shifts %0d dones %0d overlap %0d required %h 16 1 0",
                         p, seq[15:0], sen_cnt, n_done, overlap, exp[15:0]);
            end
            checks++;
            if (done_cyc !== exp_done(LEN_A)) begin
                errors++;
                $display("FAIL rand_latency%0d: got %0d required %0d", p, done_cyc, exp_done(LEN_A));
            end
            checks++;
            if (rb_a !== exp_rb(snap)) begin
                errors++;
                $display("FAIL rand_rb%0d: got %h required %h", p, rb_a, exp_rb(snap));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_readback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
